// File: rtl/dpram_fifo_ctrl_pkg.sv
// Shared constants and types for the dpram-backed FIFO controller.
package dpram_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  // Pointer type for the default configuration: one extra bit beyond the
  // RAM address so that full and empty can be told apart.
  typedef logic [ADDR_W_DEF:0] ptr_t;

  // Storage capacity for a given RAM address width.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// Bundle of the push/pop handshakes and the dpram port A/B connections.
//
// Handshake semantics: a push is taken on a rising clk edge when wr_en is
// high and full is low; a word is popped on a rising clk edge when rd_valid
// and rd_ready are both high. rd_valid never depends on rd_ready, and rd_data
// stays stable while rd_valid is high and rd_ready is low.
//
// The master modport is the FIFO controller; the slave modport is the
// surrounding logic (producer, consumer and the dpram instance).
interface dpram_fifo_ctrl_if #(
  parameter int DATA_W = dpram_pkg::DATA_W_DEF,
  parameter int ADDR_W = dpram_pkg::ADDR_W_DEF
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              overflow;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   count;
  logic              ram_we_a;
  logic [ADDR_W-1:0] ram_addr_a;
  logic [DATA_W-1:0] ram_din_a;
  logic              ram_we_b;
  logic [ADDR_W-1:0] ram_addr_b;
  logic [DATA_W-1:0] ram_din_b;
  logic [DATA_W-1:0] ram_dout_b;

  modport master (
    input  wr_en, wr_data, rd_ready, ram_dout_b,
    output full, overflow, rd_valid, rd_data, count,
    output ram_we_a, ram_addr_a, ram_din_a, ram_we_b, ram_addr_b, ram_din_b
  );

  modport slave (
    output wr_en, wr_data, rd_ready, ram_dout_b,
    input  full, overflow, rd_valid, rd_data, count,
    input  ram_we_a, ram_addr_a, ram_din_a, ram_we_b, ram_addr_b, ram_din_b
  );
endinterface

// File: rtl/dpram_fifo_ctrl_out_skid.sv
// Two-entry in-order output buffer that absorbs the registered RAM read data
// and presents it on the valid/ready pop side.
module fifo_out_skid import dpram_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              pop,
  output logic [1:0]        out_cnt
);
  logic [DATA_W-1:0] slot [2];
  logic              head;
  logic              tail;
  logic [1:0]        cnt_q;

  // Head slot is the oldest word; the producer side never captures into a
  // full buffer unless the head is leaving in the same cycle.
  assign rd_valid = (cnt_q != 2'd0);
  assign rd_data  = slot[head];
  assign pop      = rd_valid && rd_ready;
  assign out_cnt  = cnt_q;

  // Slot storage, ring indices and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot[0] <= '0;
      slot[1] <= '0;
      head    <= 1'b0;
      tail    <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      if (cap) begin
        slot[tail] <= cap_data;
        tail       <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      cnt_q <= cnt_q + {1'b0, cap} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving an external dual-port RAM: port A writes pushed
// words, port B prefetches into a small output buffer for first-word-fall-
// through reads.
module dpram_fifo_ctrl import dpram_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  dpram_fifo_ctrl_if.master bus
);
  localparam int              DEPTH   = depth_of(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic [ADDR_W:0]   count_q;
  logic              overflow_q;
  logic              inflight;
  logic              full;
  logic              push;
  logic              pop;
  logic              issue;
  logic [1:0]        out_cnt;
  logic [2:0]        occ_after;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;

  // full comes from the registered count, so a pop in the same cycle never
  // admits a push. rst gates push so the RAM port stays quiet during reset.
  assign full  = (count_q == DEPTH_C);
  assign push  = bus.wr_en && !full && !rst;

  // Words the output stage will hold after this cycle, counting the read
  // already in flight; a new read is only issued if it will find room.
  assign occ_after = {1'b0, out_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (wptr != rptr) && (occ_after < 3'd2);

  assign bus.ram_we_a   = push;
  assign bus.ram_addr_a = wptr[ADDR_W-1:0];
  assign bus.ram_din_a  = push ? bus.wr_data : '0;
  assign bus.ram_we_b   = 1'b0;
  assign bus.ram_addr_b = rptr[ADDR_W-1:0];
  assign bus.ram_din_b  = '0;
  assign bus.full       = full;
  assign bus.overflow   = overflow_q;
  assign bus.count      = count_q;
  assign bus.rd_valid   = skid_valid;
  assign bus.rd_data    = skid_data;

  // Pointers, in-flight read flag, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      inflight   <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + ONE_C;
      end
      if (issue) begin
        rptr <= rptr + ONE_C;
      end
      inflight <= issue;
      count_q  <= count_q + (push ? ONE_C : '0) - (pop ? ONE_C : '0);
      if (bus.wr_en && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  fifo_out_skid #(.DATA_W(DATA_W)) u_out_skid (
    .clk      (clk),
    .rst      (rst),
    .cap      (inflight),
    .cap_data (bus.ram_dout_b),
    .rd_ready (bus.rd_ready),
    .rd_valid (skid_valid),
    .rd_data  (skid_data),
    .pop      (pop),
    .out_cnt  (out_cnt)
  );
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl with a behavioural dpram attached.
module tb_dpram_fifo_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic clk;
  logic rst;

  dpram_fifo_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dpram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- dpram model (latency-1 read on port B) ----------------
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_we_a) mem[bus.ram_addr_a] <= bus.ram_din_a;
    bus.ram_dout_b <= mem[bus.ram_addr_b];
  end

  // ---------------- scoreboard state ----------------
  logic [DATA_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int m_count  = 0;
  int m_wptr   = 0;
  bit m_ovf    = 0;
  bit m_full;
  bit m_push;
  bit m_pop;
  bit chk_cont = 0;
  bit seen_valid = 0;
  int wrap_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- monitor: reference model + pop checking ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_count    = 0;
      m_wptr     = 0;
      m_ovf      = 0;
      seen_valid = 0;
    end else begin
      m_full = (m_count == DEPTH);
      m_push = bus.wr_en && !m_full;
      m_pop  = bus.rd_valid && bus.rd_ready;
      check("count", 32'(bus.count), 32'(m_count));
      check("full", 32'(bus.full), 32'(m_full));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
      check("ram_we_a", 32'(bus.ram_we_a), 32'(m_push));
      check("ram_we_b", 32'(bus.ram_we_b), 32'd0);
      if (chk_cont) begin
        if (bus.rd_valid) seen_valid = 1;
        else if (seen_valid && exp_q.size() != 0) check("rd_valid_gap", 32'(bus.rd_valid), 32'd1);
      end else begin
        seen_valid = 0;
      end
      if (m_push) begin
        check("ram_addr_a", 32'(bus.ram_addr_a), 32'(m_wptr % DEPTH));
        check("ram_din_a", 32'(bus.ram_din_a), 32'(bus.wr_data));
        if ((m_wptr % DEPTH) == 0 && m_wptr != 0) wrap_cnt++;
        exp_q.push_back(bus.wr_data);
        m_wptr++;
      end
      if (m_pop) begin
        if (exp_q.size() == 0) check("pop_unexpected", 32'(bus.rd_data), 32'hFFFF_FFFF);
        else check("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
      end
      if (bus.wr_en && m_full) m_ovf = 1;
      m_count = m_count + int'(m_push) - int'(m_pop);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_full"}, 32'(bus.full), 32'd0);
    check({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
    check({tag, "_count"}, 32'(bus.count), 32'd0);
    check({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
    check({tag, "_ram_we_a"}, 32'(bus.ram_we_a), 32'd0);
    check({tag, "_ram_addr_a"}, 32'(bus.ram_addr_a), 32'd0);
    check({tag, "_ram_addr_b"}, 32'(bus.ram_addr_b), 32'd0);
    check({tag, "_ram_din_a"}, 32'(bus.ram_din_a), 32'd0);
    check({tag, "_rd_data"}, 32'(bus.rd_data), 32'd0);
  endtask

  // Reset pulse of 15 ns with a push request held high to show it is ignored.
  task automatic do_reset(input string tag);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h5A;
    rst = 1'b1;
    #1;
    check_outputs_zero(tag);
    #14;
    bus.wr_en = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic drain(input string tag, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      step();
      n++;
    end
    check({tag, "_drain_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wraps0;
    bus.wr_en    = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;
    rst          = 1'b0;
    #1;
    do_reset("reset");

    // Single push: visible on port A at once, out three cycles later.
    bus.rd_ready = 1'b1;
    bus.wr_en    = 1'b1;
    bus.wr_data  = 8'hA5;
    #1;
    check("single_we_a", 32'(bus.ram_we_a), 32'd1);
    check("single_addr_a", 32'(bus.ram_addr_a), 32'd0);
    check("single_din_a", 32'(bus.ram_din_a), 32'hA5);
    step();
    bus.wr_en = 1'b0;
    check("single_valid_n1", 32'(bus.rd_valid), 32'd0);
    step();
    check("single_valid_n2", 32'(bus.rd_valid), 32'd0);
    step();
    check("single_valid_n3", 32'(bus.rd_valid), 32'd1);
    check("single_data_n3", 32'(bus.rd_data), 32'hA5);
    step();
    check("single_count_end", 32'(bus.count), 32'd0);

    // Fill, overflow, then drain one word per cycle.
    bus.rd_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(i);
      step();
    end
    bus.wr_en = 1'b0;
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_count", 32'(bus.count), 32'd16);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hFF;
    #1;
    check("ovf_no_write", 32'(bus.ram_we_a), 32'd0);
    step();
    bus.wr_en = 1'b0;
    check("ovf_set", 32'(bus.overflow), 32'd1);
    bus.rd_ready = 1'b1;
    repeat (DEPTH) step();
    check("drain_rate", 32'(exp_q.size()), 32'd0);
    drain("fill", 10);
    step();
    check("drain_count", 32'(bus.count), 32'd0);
    check("drain_full", 32'(bus.full), 32'd0);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);

    do_reset("reset2");

    // Wrap-around streaming at full rate.
    wraps0   = wrap_cnt;
    chk_cont = 1'b1;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(i);
      step();
    end
    bus.wr_en = 1'b0;
    drain("wrap", 50);
    chk_cont = 1'b0;
    check("wrap_count", 32'(wrap_cnt - wraps0), 32'd2);

    // Backpressure with rd_ready toggling every cycle.
    for (int i = 0; i < 20; i++) begin
      bus.wr_en    = 1'b1;
      bus.wr_data  = 8'h40 + 8'(i);
      bus.rd_ready = i[0];
      step();
    end
    bus.wr_en    = 1'b0;
    bus.rd_ready = 1'b1;
    drain("bp", 60);

    // Reset while entries are held.
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'h70 + 8'(i);
      step();
    end
    bus.wr_en = 1'b0;
    repeat (4) step();
    check("mid_count", 32'(bus.count), 32'd5);
    check("mid_valid", 32'(bus.rd_valid), 32'd1);
    do_reset("mid_reset");
    bus.rd_ready = 1'b1;
    bus.wr_en    = 1'b1;
    bus.wr_data  = 8'hC3;
    #1;
    check("post_reset_addr_a", 32'(bus.ram_addr_a), 32'd0);
    step();
    bus.wr_en = 1'b0;
    drain("post_reset", 10);
    repeat (2) step();
    check("final_count", 32'(bus.count), 32'd0);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end
endmodule
